uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8-bit UART receiver with 16x oversampling, mid-bit sampling and break handling.
// Optional even-parity bit is compiled in with `define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

`ifdef UART_RX_PARITY_EN
  function automatic logic parity_even(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q, rxd_prev_q;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]      os_cnt_q, os_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            busy_q, busy_d;
  logic            rxd_s, fall_s, tick_s, mid_s, end_s;

  assign rxd_s  = sync2_q;
  assign fall_s = rxd_prev_q & ~rxd_s;
  assign tick_s = (state_q != S_IDLE) && (tick_cnt_q == TICK_MAX);
  assign mid_s  = tick_s && (os_cnt_q == 4'd7);
  assign end_s  = tick_s && (os_cnt_q == 4'd15);

  // Synchronizer and edge-detect history reset high so an idle line shows no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rxd;
      sync2_q    <= sync1_q;
      rxd_prev_q <= sync2_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (fall_s) state_d = S_START;
        else        state_d = S_IDLE;
      end
      S_START: begin
        if (mid_s) state_d = rxd_s ? S_IDLE : S_DATA;
        else       state_d = S_START;
      end
      S_DATA: begin
        if (end_s && (bit_idx_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (end_s) state_d = S_STOP;
        else       state_d = S_PARITY;
      end
`endif
      S_STOP: begin
        if (end_s) state_d = rxd_s ? S_IDLE : S_WAIT_IDLE;
        else       state_d = S_STOP;
      end
      // A held-low line parks here so one break yields a single frame error.
      S_WAIT_IDLE: begin
        if (rxd_s) state_d = S_IDLE;
        else       state_d = S_WAIT_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit_q, par_bit_d;
  logic parity_err_q, parity_err_d;
`endif

  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    os_cnt_d    = os_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = (state_d != S_IDLE);
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif

    if (state_q == S_IDLE) begin
      tick_cnt_d = '0;
      os_cnt_d   = 4'd0;
      bit_idx_d  = 3'd0;
    end else if (tick_s) begin
      tick_cnt_d = '0;
      os_cnt_d   = os_cnt_q + 4'd1;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end

    case (state_q)
      // Re-zero the oversample phase at mid start bit so later samples land mid-bit.
      S_START: begin
        if (mid_s && !rxd_s) os_cnt_d = 4'd0;
        else                 os_cnt_d = os_cnt_d;
      end
      S_DATA: begin
        if (end_s) begin
          shift_d   = {rxd_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          shift_d   = shift_q;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (end_s) par_bit_d = rxd_s;
        else       par_bit_d = par_bit_q;
      end
`endif
      S_STOP: begin
        if (end_s) begin
          rx_data_d = shift_q;
          if (rxd_s) begin
            rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = (par_bit_q != parity_even(shift_q));
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          rx_data_d = rx_data_q;
        end
      end
      default: begin
        shift_d = shift_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      os_cnt_q    <= 4'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      os_cnt_q    <= os_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
